// File: rtl/i2s_tx_stereo.sv
// i2s_tx_stereo: stereo I2S transmitter with one-deep sample handshake, underflow pulse and optional test tone (I2S_TX_TONE_EN)
module i2s_tx_stereo #(
  parameter int DATA_W      = 16,
  parameter int SLOT_W      = 16,
  parameter int HALF_PERIOD = 16,
  parameter int TONE_FRAMES = 15
) (
  input  logic              input_clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              serial_clk,
  output logic              word_select,
  output logic              sound_bit_out,
  output logic              frame_start,
`ifdef I2S_TX_TONE_EN
  output logic              underflow,
  input  logic              tone_en
`else
  output logic              underflow
`endif
);
  localparam int FW = 2 * SLOT_W;
  localparam int PW = $clog2(FW);
  localparam int DV = $clog2(HALF_PERIOD);

  logic [DV-1:0]     r_div;
  logic [PW-1:0]     r_pos;
  logic              r_full;
  logic [DATA_W-1:0] r_pl, r_pr, r_sl, r_sr;
  logic [PW-1:0]     w_pos_n;
  int                w_pi;
  logic              w_div_end, w_shift, w_load, w_accept, w_tone;
  logic [DATA_W-1:0] w_ll, w_lr;

  assign w_div_end = r_div == DV'(HALF_PERIOD - 1);
  assign w_shift   = w_div_end && serial_clk;
  assign w_load    = w_shift && (r_pos == PW'(FW - 1));
  assign w_pos_n   = (r_pos == PW'(FW - 1)) ? '0 : r_pos + 1'b1;
  assign w_pi      = 32'(w_pos_n);
  assign s_ready   = !r_full && !w_tone;
  assign w_accept  = s_valid && s_ready;

`ifdef I2S_TX_TONE_EN
  localparam int TW = $clog2(TONE_FRAMES + 1);
  localparam logic [DATA_W-1:0] TONE = DATA_W'(8'h7D) << (DATA_W - 8);
  logic [TW-1:0]     r_tcnt;
  logic [DATA_W-1:0] w_tv;
  assign w_tone = tone_en;
  assign w_tv   = (r_tcnt == TW'(TONE_FRAMES)) ? -TONE : TONE;
  assign w_ll   = w_tone ? w_tv : (r_full ? r_pl : '0);
  assign w_lr   = w_tone ? w_tv : (r_full ? r_pr : '0);

  // Tone frame counter: TONE_FRAMES positive frames then one negative frame
  always_ff @(posedge input_clk or negedge reset)
    if (!reset) r_tcnt <= '0;
    else if (w_load && w_tone) r_tcnt <= (r_tcnt == TW'(TONE_FRAMES)) ? '0 : r_tcnt + 1'b1;
`else
  assign w_tone = 1'b0;
  assign w_ll   = r_full ? r_pl : '0;
  assign w_lr   = r_full ? r_pr : '0;
`endif

  // Bit-clock divider, frame position and frame load pulses
  always_ff @(posedge input_clk or negedge reset)
    if (!reset) begin
      r_div       <= '0;
      r_pos       <= PW'(FW - 1);
      serial_clk  <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      r_div       <= w_div_end ? '0 : r_div + 1'b1;
      serial_clk  <= w_div_end ? !serial_clk : serial_clk;
      r_pos       <= w_shift ? w_pos_n : r_pos;
      frame_start <= w_load;
      underflow   <= w_load && !r_full && !w_tone;
    end

  // One-deep pending pair; an accept on an empty load cycle waits for the next frame
  always_ff @(posedge input_clk or negedge reset)
    if (!reset) begin
      r_full <= 1'b0;
      r_pl   <= '0;
      r_pr   <= '0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_pl   <= s_left;
      r_pr   <= s_right;
    end else if (w_load && !w_tone) r_full <= 1'b0;

  // Serialiser: WS leads each channel MSB by one bit, slots zero-padded past DATA_W
  always_ff @(posedge input_clk or negedge reset)
    if (!reset) begin
      r_sl          <= '0;
      r_sr          <= '0;
      word_select   <= 1'b0;
      sound_bit_out <= 1'b0;
    end else if (w_shift) begin
      word_select <= (w_pi >= SLOT_W - 1) && (w_pi <= FW - 2);
      if (w_load) begin
        sound_bit_out <= w_ll[DATA_W-1];
        r_sl          <= w_ll << 1;
        r_sr          <= w_lr;
      end else if (w_pi < DATA_W) begin
        sound_bit_out <= r_sl[DATA_W-1];
        r_sl          <= r_sl << 1;
      end else if (w_pi >= SLOT_W && w_pi < SLOT_W + DATA_W) begin
        sound_bit_out <= r_sr[DATA_W-1];
        r_sr          <= r_sr << 1;
      end else sound_bit_out <= 1'b0;
    end
endmodule

// File: tb/tb_i2s_tx_stereo.sv
// tb_i2s_tx_stereo: scoreboard bench for the stereo I2S transmitter (default and padded-slot instances)
module tb_i2s_tx_stereo;
  logic clk = 0, rst_n = 0;
  logic sv = 0, srdy, sck, ws, sd, fs, uf;
  logic [15:0] sl = 0, sr = 0;
  logic sv2 = 0, srdy2, sck2, ws2, sd2, fs2, uf2;
  logic [15:0] sl2 = 0, sr2 = 0;
  int n_tests = 0, n_fail = 0, cyc = 0, c0 = 0, nfr = 0;

  typedef struct { logic [15:0] l; logic [15:0] r; int e; } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_tx_stereo dut (
    .input_clk(clk), .reset(rst_n), .s_valid(sv), .s_ready(srdy), .s_left(sl), .s_right(sr),
    .serial_clk(sck), .word_select(ws), .sound_bit_out(sd), .frame_start(fs),
`ifdef I2S_TX_TONE_EN
    .underflow(uf), .tone_en(1'b0)
`else
    .underflow(uf)
`endif
  );

  i2s_tx_stereo #(.DATA_W(16), .SLOT_W(24), .HALF_PERIOD(2), .TONE_FRAMES(15)) dut2 (
    .input_clk(clk), .reset(rst_n), .s_valid(sv2), .s_ready(srdy2), .s_left(sl2), .s_right(sr2),
    .serial_clk(sck2), .word_select(ws2), .sound_bit_out(sd2), .frame_start(fs2),
`ifdef I2S_TX_TONE_EN
    .underflow(uf2), .tone_en(1'b0)
`else
    .underflow(uf2)
`endif
  );

  // Scoreboard monitor for the default instance: pops the pair accepted before each load and decodes the frame
  logic col = 0, psck = 0, euf;
  logic [31:0] fr;
  logic [15:0] el, er;
  int bi = 0, wse = 0, last_fs = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      col = 0; last_fs = 0; psck = 0;
    end else begin
      if (fs) begin
        if (last_fs != 0) begin
          n_tests++;
          if (cyc - last_fs != 1024) begin n_fail++; $display("FAIL frame_period: got %0d want 1024", cyc - last_fs); end
        end
        last_fs = cyc;
        euf = !(q.size() > 0 && q[0].e < cyc);
        if (!euf) begin el = q[0].l; er = q[0].r; void'(q.pop_front()); end
        else begin el = 0; er = 0; end
        n_tests++;
        if (uf !== euf) begin n_fail++; $display("FAIL underflow_flag: got %b want %b", uf, euf); end
        col = 1; bi = 0; wse = 0;
      end
      if (sck && !psck && col) begin
        fr[31-bi] = sd;
        if (ws !== (bi >= 15 && bi <= 30)) wse++;
        bi++;
        if (bi == 32) begin
          n_tests++;
          if (fr !== {el, er} || wse != 0) begin
            n_fail++; $display("FAIL frame_data: got %h ws_err %0d want %h", fr, wse, {el, er});
          end
          col = 0; nfr++;
        end
      end
      psck = sck;
    end
  end

  task automatic send(input logic [15:0] l, input logic [15:0] r, output int e);
    int t = 0;
    @(negedge clk); sv = 1; sl = l; sr = r;
    while (!srdy && t < 3000) begin @(negedge clk); t++; end
    if (!srdy) begin n_tests++; n_fail++; $display("FAIL send_timeout: got ready 0 want 1"); e = 0; end
    else begin e = cyc + 1; q.push_back('{l: l, r: r, e: e}); @(posedge clk); #1; end
    sv = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((q.size() != 0 || col) && t < 5000) begin @(negedge clk); t++; end
    if (q.size() != 0 || col) begin n_tests++; n_fail++; $display("FAIL idle_timeout: got %0d queued want 0", q.size()); end
  endtask

  task automatic wait_fs1(output int e);
    int t = 0;
    do begin @(negedge clk); t++; end while (!fs && t < 3000);
    if (!fs) begin n_tests++; n_fail++; $display("FAIL fs_timeout: got 0 want 1"); end
    e = cyc;
  endtask

  task automatic wait_fs2(output int e);
    int t = 0;
    do begin @(negedge clk); t++; end while (!fs2 && t < 500);
    if (!fs2) begin n_tests++; n_fail++; $display("FAIL fs2_timeout: got 0 want 1"); end
    e = cyc;
  endtask

  task automatic collect2(output logic [15:0] l, output logic [15:0] r, output int pe, output int we);
    logic p;
    l = 0; r = 0; pe = 0; we = 0; p = sck2;
    for (int i = 0; i < 48; i++) begin
      int t = 0;
      while (1) begin
        @(negedge clk); t++;
        if ((sck2 && !p) || t > 100) break;
        p = sck2;
      end
      p = sck2;
      if (t > 100) we++;
      if (i < 16) l[15-i] = sd2;
      else if (i >= 24 && i < 40) r[39-i] = sd2;
      else if (sd2) pe++;
      if (ws2 !== (i >= 23 && i <= 46)) we++;
    end
  endtask

  task automatic test_reset();
    int t = 0;
    rst_n = 0;
    repeat (10) @(negedge clk);
    n_tests++;
    if ({sck, ws, sd, fs, uf, sck2, ws2, sd2, fs2, uf2} !== 10'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 0", {sck, ws, sd, fs, uf, sck2, ws2, sd2, fs2, uf2});
    end
    n_tests++;
    if (srdy !== 1'b1 || srdy2 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b%b want 11", srdy, srdy2); end
    rst_n = 1; c0 = cyc;
    while (!sck && t < 100) begin @(negedge clk); t++; end
    n_tests++;
    if (cyc - c0 != 16) begin n_fail++; $display("FAIL sck_first_rise: got %0d want 16", cyc - c0); end
  endtask

  task automatic test_bit_order();
    int e;
    send(16'hA5C3, 16'h3C5A, e);
    wait_fs1(e);
    n_tests++;
    if (e - c0 != 32) begin n_fail++; $display("FAIL first_frame_start: got %0d want 32", e - c0); end
    n_tests++;
    if (sck !== 1'b0) begin n_fail++; $display("FAIL sck_fall_at_load: got %b want 0", sck); end
    wait_idle();
    n_tests++;
    if (nfr != 1) begin n_fail++; $display("FAIL bit_order_frames: got %0d want 1", nfr); end
  endtask

  task automatic test_back_to_back();
    int e, pe = 0;
    for (int k = 0; k < 6; k++) begin
      send(16'h1000 + 16'(k), 16'h2000 + 16'(k), e);
      @(negedge clk);
      n_tests++;
      if (srdy !== 1'b0) begin n_fail++; $display("FAIL ready_after_accept %0d: got %b want 0", k, srdy); end
      if (k >= 2) begin
        n_tests++;
        if (e - pe != 1024) begin n_fail++; $display("FAIL accept_spacing %0d: got %0d want 1024", k, e - pe); end
      end
      pe = e;
    end
    wait_idle();
  endtask

  task automatic test_underflow();
    int e;
    wait_fs1(e);
    n_tests++;
    if (uf !== 1'b1) begin n_fail++; $display("FAIL underflow_pulse: got %b want 1", uf); end
    @(negedge clk);
    n_tests++;
    if (uf !== 1'b0) begin n_fail++; $display("FAIL underflow_width: got %b want 0", uf); end
    send(16'h1234, 16'h4321, e);
    wait_idle();
  endtask

  task automatic test_padding_race();
    int e0, e1, e2, pe, we;
    logic [15:0] l, r;
    wait_fs2(e0);
    @(negedge clk);
    n_tests++;
    if (srdy2 !== 1'b1) begin n_fail++; $display("FAIL ready2_idle: got %b want 1", srdy2); end
    sv2 = 1; sl2 = 16'hBEEF; sr2 = 16'h0F0F;
    @(posedge clk); #1; sv2 = 0;
    wait_fs2(e1);
    n_tests++;
    if (uf2 !== 1'b0 || e1 - e0 != 192) begin n_fail++; $display("FAIL pad_load: got uf %b period %0d want 0 192", uf2, e1 - e0); end
    collect2(l, r, pe, we);
    n_tests++;
    if ({l, r} !== 32'hBEEF0F0F) begin n_fail++; $display("FAIL pad_data: got %h want beef0f0f", {l, r}); end
    n_tests++;
    if (pe != 0 || we != 0) begin n_fail++; $display("FAIL pad_zero_ws: got pad %0d ws %0d want 0 0", pe, we); end
    wait_fs2(e2);
    n_tests++;
    if (uf2 !== 1'b1) begin n_fail++; $display("FAIL pad_underflow: got %b want 1", uf2); end
    while (cyc < e2 + 191) @(negedge clk);
    sv2 = 1; sl2 = 16'h5A5A; sr2 = 16'hC3C3;
    @(posedge clk); #1; sv2 = 0;
    @(negedge clk);
    n_tests++;
    if ({fs2, uf2, srdy2} !== 3'b110) begin n_fail++; $display("FAIL race_load: got %b want 110", {fs2, uf2, srdy2}); end
    collect2(l, r, pe, we);
    n_tests++;
    if ({l, r} !== 32'h0 || pe != 0) begin n_fail++; $display("FAIL race_zero_frame: got %h want 0", {l, r}); end
    wait_fs2(e1);
    n_tests++;
    if (uf2 !== 1'b0) begin n_fail++; $display("FAIL race_next_uf: got %b want 0", uf2); end
    collect2(l, r, pe, we);
    n_tests++;
    if ({l, r} !== 32'h5A5AC3C3 || we != 0) begin n_fail++; $display("FAIL race_data: got %h ws %0d want 5a5ac3c3", {l, r}, we); end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_back_to_back();
    test_underflow();
    test_padding_race();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/i2s_tx_stereo.md
# i2s_tx_stereo

Parametrised stereo I2S transmitter with sample handshake and underflow reporting. Divides `input_clk` to generate the serial bit clock internally, in a single clock domain, and serialises one left/right sample pair per frame. Frame width is parametrised. Feeds the external DAC and replaces fixed-width, single-channel, hard-wired test-tone transmitters. An optional built-in test-tone source is selected by macro.

## Interface
- `DATA_W`, 16: sample width in bits; 8 ≤ DATA_W ≤ SLOT_W.
- `SLOT_W`, 16: serial_clk periods per channel slot. The frame is 2*SLOT_W bits.
- `HALF_PERIOD`, 16: input_clk cycles per serial_clk half-period; ≥ 2.
- `TONE_FRAMES`, 15: frames per tone half-cycle. Used only with `I2S_TX_TONE_EN`.
- `input_clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  sample pair valid.
- `s_ready`  out  1  transmitter can accept a pair.
- `s_left`  in  DATA_W  left sample, two's complement.
- `s_right`  in  DATA_W  right sample, two's complement.
- `serial_clk`  out  1  I2S bit clock (SCK), registered.
- `word_select`  out  1  I2S WS; 0 = left, 1 = right; registered.
- `sound_bit_out`  out  1  I2S serial data (SD), MSB first, registered.
- `frame_start`  out  1  one-cycle pulse when a new frame is loaded.
- `underflow`  out  1  one-cycle pulse when a frame loads with no pending pair.
- `tone_en`  in  1  selects the internal tone. Present only with `I2S_TX_TONE_EN`.

## Operation
- **Divider:** counter `div` runs 0..HALF_PERIOD-1 and wraps.
  - At `div == HALF_PERIOD-1`, `serial_clk` toggles.
  - A toggle from 1 to 0 is a *shift event*.
- **Frame position:** `pos` runs 0..2*SLOT_W-1. It advances by 1 on each shift event and wraps from 2*SLOT_W-1 to 0.
- **Frame load:** happens on the shift event where `pos` wraps to 0.
  - If the pending register is full: copy it to the shift registers, clear pending, pulse `frame_start`.
  - If it is empty: load zeros for both channels, pulse `frame_start` and `underflow`.
- **Pending register:** one pair deep. `s_ready = !pending_full`.
  - A pair is accepted on any cycle with `s_valid && s_ready`.
  - If an accept and a load fall on the same cycle while pending is empty, the load underflows (zeros) and the accepted pair goes into pending for the next frame.
- **Data output,** updated only on shift events, using the new `pos`:
  - `pos < DATA_W`: `sound_bit_out = left[DATA_W-1-pos]`.
  - `SLOT_W ≤ pos < SLOT_W+DATA_W`: `sound_bit_out = right[DATA_W-1-(pos-SLOT_W)]`.
  - Otherwise: `sound_bit_out = 0` (zero padding).
- **Word select:** `word_select = 1` when `SLOT_W-1 ≤ pos ≤ 2*SLOT_W-2`, else 0. WS therefore leads the MSB of each channel by one bit, as I2S requires.
- `s_valid` deasserted: no effect. Samples are held; there is no timeout.

## Timing
- **Reset values:**
  - `serial_clk`, `word_select`, `sound_bit_out`, `frame_start`, `underflow` = 0.
  - `div` = 0, `pos` = 2*SLOT_W-1, pending empty (`s_ready` = 1), shift registers = 0.
- **After reset release:**
  - `serial_clk` rises after HALF_PERIOD cycles.
  - The first shift event and first frame load occur after 2*HALF_PERIOD cycles.
- SCK period is 2*HALF_PERIOD cycles. Frame period is 4*SLOT_W*HALF_PERIOD cycles; defaults give 1024.
- SD and WS change in the same cycle as the SCK falling edge. The receiver samples on the rising edge, HALF_PERIOD cycles later.
- `s_ready` falls the cycle after an accept. It rises the cycle after the load that empties pending.
- Sample latency: a pair accepted while pending is empty reaches the shift registers at the next frame load.
- Reset asserted mid-frame: all state clears immediately and asynchronously. A pending pair is discarded; no underflow pulse.

## Configuration
- **With `I2S_TX_TONE_EN` defined:** adds the `tone_en` port and a frame counter.
  - While `tone_en = 1`, each frame load takes both channels from the tone.
  - The tone is +T for TONE_FRAMES frames, then −T for one frame (a 16-frame cycle at the default), where T = 8'h7D << (DATA_W-8). At DATA_W = 16 the tone values are 16'h7D00 and 16'h8300.
  - In tone mode `s_ready = 0` and `underflow` is never pulsed.
- **Without the macro:** no `tone_en` port and no tone logic; behaviour is as in Operation.

## Test plan
- **Reset:** defaults; hold reset low 10 cycles, release → `serial_clk` toggles every 16 cycles, first `frame_start` at cycle 32, `s_ready` = 1.
- **Bit order:** push left = 16'hA5C3, right = 16'h3C5A before the first load → sample SD on SCK rising edges. Expect WS low for bits 1..15 of the left slot and high for the right slot. Bits decode to exactly A5C3 and 3C5A.
- **Back-pressure:** hold `s_valid` = 1 with incrementing data → `s_ready` low between loads. Exactly one pair is accepted per 1024-cycle frame; no data is skipped.
- **Underflow:** stop supplying pairs → the next load pulses `underflow` for 1 cycle and SD is all zeros for that frame. Resuming with 16'h1234 outputs it on the following frame.
- **Padding and race:** DATA_W = 16, SLOT_W = 24 → 8 zero bits after each LSB, WS transitions at pos 23 and 47. Asserting `s_valid` on the load cycle with pending empty → `underflow` pulses and the pair is sent in the next frame.
- **Tone (`I2S_TX_TONE_EN`):** with `tone_en` = 1, frames carry 16'h7D00 for 15 frames, then 16'h8300 for 1 frame, with `s_ready` = 0.
